// File: rtl/ps2_if.sv
// Processor-bus IPIF slave port for the PS/2 transceiver: write/read chip
// enables, data in both directions and the acknowledge/error returns.
interface ps2_if;
  logic [31:0] Bus2IP_Data;
  logic [3:0]  Bus2IP_BE;
  logic [1:0]  Bus2IP_RdCE;
  logic [1:0]  Bus2IP_WrCE;
  logic [31:0] IP2Bus_Data;
  logic        IP2Bus_RdAck;
  logic        IP2Bus_WrAck;
  logic        IP2Bus_Error;

  modport master (
    output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/ps2.sv
// PS/2-style serial transceiver: bus-written bytes go out as 11-bit odd-parity
// frames on Dout, frames arriving on Din are deframed into a readable byte.
module ps2 #(
  parameter int BIT_CYCLES = 16
) (
  input  logic        Bus2IP_Clk,
  input  logic        Bus2IP_Resetn,
  ps2_if.slave        bus,
  output logic        IP_Interupt,
  output logic [10:0] bitsReceived,
  output logic [10:0] bitsToSend,
  output logic        Dout,
  input  logic        Din
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_t;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic [CW-1:0] tx_cyc, rx_cyc;
  logic [3:0]    tx_bits, rx_bits;
  logic [7:0]    tx_byte, rx_byte;
  logic          rx_valid, frame_error, tx_busy;
  logic          wr_reg1, rd_reg0;
  logic          tx_bit_end, tx_done;
  logic          rx_half, rx_full, rx_stop, frame_ok;
  logic [10:0]   rx_shifted;
  logic [31:0]   rd_data;
  logic          unused_bus;

  assign wr_reg1    = bus.Bus2IP_WrCE[0];
  assign rd_reg0    = bus.Bus2IP_RdCE[1];
  assign tx_busy    = (tx_state == TX_SEND);
  assign tx_bit_end = (tx_cyc == BIT_LAST);
  assign tx_done    = tx_bit_end && (tx_bits == 4'd10);

  assign rx_half    = (rx_cyc == HALF_LAST);
  assign rx_full    = (rx_cyc == BIT_LAST);
  assign rx_stop    = (rx_state == RX_DATA) && rx_full && (rx_bits == 4'd10);
  assign rx_shifted = {Din, bitsReceived[10:1]};
  // Judged on the vector as it will look once the stop bit is shifted in.
  assign frame_ok   = !rx_shifted[0] && rx_shifted[10] && (^rx_shifted[9:1]);

  assign Dout        = tx_busy ? bitsToSend[0] : 1'b1;
  assign IP_Interupt = rx_valid;

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Resetn) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_IDLE;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (wr_reg1) tx_next = TX_SEND;
      TX_SEND: if (tx_done) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // A start bit that has gone high again by mid-bit is treated as a glitch.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!Din) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = Din ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_stop) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Resetn) begin
      bitsToSend <= 11'h7FF;
      tx_cyc     <= '0;
      tx_bits    <= '0;
      tx_byte    <= '0;
    end else if (tx_state == TX_IDLE) begin
      if (wr_reg1) begin
        bitsToSend <= {1'b1, ~^bus.Bus2IP_Data[7:0], bus.Bus2IP_Data[7:0], 1'b0};
        tx_byte    <= bus.Bus2IP_Data[7:0];
        tx_cyc     <= '0;
        tx_bits    <= '0;
      end
    end else if (tx_bit_end) begin
      bitsToSend <= {1'b1, bitsToSend[10:1]};
      tx_cyc     <= '0;
      tx_bits    <= tx_bits + 4'd1;
    end else begin
      tx_cyc <= tx_cyc + CW'(1);
    end
  end

  // Read-clear comes first so a frame completing in the same cycle wins.
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Resetn) begin
      bitsReceived <= '0;
      rx_cyc       <= '0;
      rx_bits      <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      if (rd_reg0) begin
        rx_valid    <= 1'b0;
        frame_error <= 1'b0;
      end
      case (rx_state)
        RX_START: begin
          if (rx_half) begin
            rx_cyc <= '0;
            if (!Din) begin
              bitsReceived <= rx_shifted;
              rx_bits      <= 4'd1;
            end
          end else begin
            rx_cyc <= rx_cyc + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_full) begin
            rx_cyc       <= '0;
            bitsReceived <= rx_shifted;
            rx_bits      <= rx_bits + 4'd1;
            if (rx_stop) begin
              if (frame_ok) begin
                rx_byte  <= rx_shifted[8:1];
                rx_valid <= 1'b1;
              end else begin
                frame_error <= 1'b1;
              end
            end
          end else begin
            rx_cyc <= rx_cyc + CW'(1);
          end
        end
        default: begin
          rx_cyc  <= '0;
          rx_bits <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (bus.Bus2IP_RdCE[1])
      rd_data = {21'b0, tx_busy, frame_error, rx_valid, rx_byte};
    else if (bus.Bus2IP_RdCE[0])
      rd_data = {23'b0, tx_busy, tx_byte};
  end

  assign bus.IP2Bus_Data  = rd_data;
  assign bus.IP2Bus_RdAck = |bus.Bus2IP_RdCE;
  assign bus.IP2Bus_WrAck = |bus.Bus2IP_WrCE;
  assign bus.IP2Bus_Error = 1'b0;

  assign unused_bus = ^{bus.Bus2IP_BE, bus.Bus2IP_Data[31:8]};

endmodule

// File: tb/tb_ps2.sv
// Self-checking bench for ps2: fixed loopback vectors, busy/glitch/reset
// sequences, and random direct-driven frames against a frame-level model.
module tb_ps2;
  localparam int B = 8;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        din_drv = 1'b1;
  logic        loopback = 1'b0;
  logic        interrupt, dout, din;
  logic [10:0] bits_received, bits_to_send;

  int assertions = 0;
  int failures = 0;

  logic [7:0] model_byte = 8'h00;
  logic       model_valid = 1'b0;
  logic       model_fe = 1'b0;

  ps2_if bus_if ();

  assign din = loopback ? dout : din_drv;

  ps2 #(.BIT_CYCLES(B)) dut (
    .Bus2IP_Clk    (clock),
    .Bus2IP_Resetn (reset),
    .bus           (bus_if),
    .IP_Interupt   (interrupt),
    .bitsReceived  (bits_received),
    .bitsToSend    (bits_to_send),
    .Dout          (dout),
    .Din           (din)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic busWrite(input logic [1:0] ce, input logic [31:0] data);
    bus_if.Bus2IP_WrCE = ce;
    bus_if.Bus2IP_Data = data;
    #1;
    checkOutput("write ack", bus_if.IP2Bus_WrAck, 1'b1);
    @(posedge clock);
    #1;
    bus_if.Bus2IP_WrCE = 2'b00;
    bus_if.Bus2IP_Data = 32'h0;
  endtask

  task automatic busRead(input logic [1:0] ce, output logic [31:0] data);
    bus_if.Bus2IP_RdCE = ce;
    #1;
    data = bus_if.IP2Bus_Data;
    checkOutput("read ack", bus_if.IP2Bus_RdAck, 1'b1);
    @(posedge clock);
    #1;
    bus_if.Bus2IP_RdCE = 2'b00;
  endtask

  task automatic waitInterrupt(input int budget, input string name);
    int waited = 0;
    while (!interrupt && waited < budget) begin
      tick();
      waited++;
    end
    checkOutput(name, interrupt, 1'b1);
  endtask

  // Frame built from the protocol rules: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] buildFrame(input logic [7:0] d);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i + 1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic logic [31:0] expReg0();
    return {21'b0, 1'b0, model_fe, model_valid, model_byte};
  endfunction

  task automatic driveFrame(input logic [10:0] f);
    for (int k = 0; k < 11; k++) begin
      din_drv = f[k];
      repeat (B) @(posedge clock);
      #1;
    end
    din_drv = 1'b1;
    repeat (2 * B) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] rd;
    loopback = 1'b1;
    busWrite(2'b01, {24'h0, v.data});
    checkOutput("bitsToSend load", bits_to_send, v.frame);
    for (int j = 0; j < 11 * B; j++) begin
      checkOutput("Dout bit", dout, v.frame[j / B]);
      tick();
    end
    checkOutput("Dout idle after frame", dout, 1'b1);
    waitInterrupt(4 * B, "loopback interrupt");
    busRead(2'b01, rd);
    checkOutput("reg1 tx byte", rd, {23'b0, 1'b0, v.data});
    busRead(2'b10, rd);
    checkOutput("reg0 rx byte", rd, {23'b0, 1'b1, v.data});
    checkOutput("interrupt cleared", interrupt, 1'b0);
    model_byte  = v.data;
    model_valid = 1'b0;
    model_fe    = 1'b0;
    loopback    = 1'b0;
  endtask

  // Bus-level rules hold every cycle: acks track chip enables, error never set.
  always @(negedge clock) begin
    checkOutput("bus protocol {err,wrack,rdack}",
                {29'b0, bus_if.IP2Bus_Error, bus_if.IP2Bus_WrAck, bus_if.IP2Bus_RdAck},
                {29'b0, 1'b0, |bus_if.Bus2IP_WrCE, |bus_if.Bus2IP_RdCE});
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[4];
    logic [31:0] rd;
    logic [10:0] f;
    logic [7:0]  d;
    int          kind;
    int          skip;

    vecs[0] = '{data: 8'h4B, frame: 11'h696};
    vecs[1] = '{data: 8'h00, frame: 11'h600};
    vecs[2] = '{data: 8'hFF, frame: 11'h7FE};
    vecs[3] = '{data: 8'h01, frame: 11'h402};

    bus_if.Bus2IP_Data = 32'h0;
    bus_if.Bus2IP_BE   = 4'hF;
    bus_if.Bus2IP_RdCE = 2'b00;
    bus_if.Bus2IP_WrCE = 2'b00;

    $display("[TB] reset");
    tick();
    reset = 1'b0;
    checkOutput("reset Dout", dout, 1'b1);
    checkOutput("reset bitsToSend", bits_to_send, 11'h7FF);
    checkOutput("reset bitsReceived", bits_received, 11'h000);
    checkOutput("reset interrupt", interrupt, 1'b0);
    checkOutput("reset read data idle", bus_if.IP2Bus_Data, 32'h0);
    busRead(2'b10, rd);
    checkOutput("reset reg0", rd, 32'h0);
    busRead(2'b01, rd);
    checkOutput("reset reg1", rd, 32'h0);

    $display("[TB] loopback vectors");
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    $display("[TB] busy write");
    loopback = 1'b1;
    busWrite(2'b01, 32'h11);
    repeat (2 * B) tick();
    busWrite(2'b01, 32'h22);
    busRead(2'b01, rd);
    checkOutput("reg1 busy", rd, 32'h111);
    waitInterrupt(12 * B, "busy frame interrupt");
    repeat (B) tick();
    for (int j = 0; j < 2 * B; j++) begin
      checkOutput("no second frame", dout, 1'b1);
      tick();
    end
    busRead(2'b01, rd);
    checkOutput("reg1 after busy frame", rd, 32'h011);
    busRead(2'b10, rd);
    checkOutput("reg0 after busy frame", rd, 32'h111);
    model_byte = 8'h11;
    loopback   = 1'b0;

    $display("[TB] framing error");
    f = buildFrame(8'hA5);
    f[10] = 1'b0;
    driveFrame(f);
    model_fe = 1'b1;
    checkOutput("framing error no interrupt", interrupt, 1'b0);
    busRead(2'b10, rd);
    checkOutput("framing error reg0", rd, expReg0());
    model_fe = 1'b0;

    $display("[TB] start-bit glitch");
    din_drv = 1'b0;
    repeat (2) tick();
    din_drv = 1'b1;
    repeat (3 * B) tick();
    checkOutput("glitch no interrupt", interrupt, 1'b0);
    busRead(2'b10, rd);
    checkOutput("glitch reg0", rd, expReg0());

    $display("[TB] random frames");
    for (int n = 0; n < 10; n++) begin
      d    = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 2);
      skip = $urandom_range(0, 1);
      f = buildFrame(d);
      if (kind == 1) f[9] = ~f[9];
      if (kind == 2) f[10] = 1'b0;
      driveFrame(f);
      if (kind == 0) begin
        model_byte  = d;
        model_valid = 1'b1;
      end else begin
        model_fe = 1'b1;
      end
      checkOutput("random interrupt", interrupt, model_valid);
      if (skip == 0 || n == 9) begin
        busRead(2'b10, rd);
        checkOutput("random reg0", rd, expReg0());
        model_valid = 1'b0;
        model_fe    = 1'b0;
      end
    end

    $display("[TB] reset mid-frame");
    loopback = 1'b1;
    busWrite(2'b01, 32'h5A);
    repeat (3 * B) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid-frame reset Dout", dout, 1'b1);
    checkOutput("mid-frame reset bitsToSend", bits_to_send, 11'h7FF);
    checkOutput("mid-frame reset bitsReceived", bits_received, 11'h000);
    repeat (12 * B) tick();
    checkOutput("mid-frame reset no interrupt", interrupt, 1'b0);
    busRead(2'b10, rd);
    checkOutput("mid-frame reset reg0", rd, 32'h0);
    busRead(2'b01, rd);
    checkOutput("mid-frame reset reg1", rd, 32'h0);
    loopback = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
